// File: rtl/button_conditioner.sv
// Conditions the L/C/R push-buttons into synchronised, debounced levels and one-cycle press pulses.
// Define BTN_ONEHOT_ARB_EN to make the pulse outputs one-hot with priority C > L > R.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTNL_IN,
  input  logic       BTNC_IN,
  input  logic       BTNR_IN,
  output logic       BTNL,
  output logic       BTNC,
  output logic       BTNR,
  output logic [2:0] BTN_LEVEL
);

  localparam int               NUM_LANES = 3;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Lane order is {L,C,R} so the level vector maps straight onto BTN_LEVEL.
  logic [NUM_LANES-1:0] raw;
  logic [NUM_LANES-1:0] lvl;
  logic [NUM_LANES-1:0] pulse_raw;
  logic [NUM_LANES-1:0] pulse_d, pulse_q;

  assign raw = {BTNL_IN, BTNC_IN, BTNR_IN};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      hit_d    = 1'b0;
      if (sync2_q != stable_q) begin
        if (cnt_q == CNT_MAX) begin
          stable_d = sync2_q;
          hit_d    = sync2_q;  // only the rising change is a press
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync1_q  <= raw[g];
        sync2_q  <= sync1_q;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
      end
    end

    assign lvl[g]       = stable_q;
    assign pulse_raw[g] = hit_d;
  end

  // Arbitration sits before the pulse register so outputs stay registered.
  always_comb begin
`ifdef BTN_ONEHOT_ARB_EN
    pulse_d = '0;
    if (pulse_raw[1])      pulse_d[1] = 1'b1;
    else if (pulse_raw[2]) pulse_d[2] = 1'b1;
    else                   pulse_d[0] = pulse_raw[0];
`else
    pulse_d = pulse_raw;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) pulse_q <= '0;
    else       pulse_q <= pulse_d;
  end

  assign BTNL      = pulse_q[2];
  assign BTNC      = pulse_q[1];
  assign BTNR      = pulse_q[0];
  assign BTN_LEVEL = lvl;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed test-plan scenarios plus random
// bouncing/reset traffic checked against a window-based debounce reference model.
module tb_button_conditioner;

  localparam int DC = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       BTNL_IN = 1'b0, BTNC_IN = 1'b0, BTNR_IN = 1'b0;
  logic       BTNL, BTNC, BTNR;
  logic [2:0] BTN_LEVEL;

  button_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .CLK(CLK), .RESET(RESET),
    .BTNL_IN(BTNL_IN), .BTNC_IN(BTNC_IN), .BTNR_IN(BTNR_IN),
    .BTNL(BTNL), .BTNC(BTNC), .BTNR(BTNR), .BTN_LEVEL(BTN_LEVEL)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: raw is seen two edges late; the level flips once the last DC
  // seen samples all disagree with it; a pulse marks a flip to 1.
  logic [2:0]    m_d0, m_d1, m_stable, m_pulse;
  logic [DC-1:0] m_win [3];

  task automatic model_edge(input logic [2:0] raw, input logic rst);
    logic [2:0] seen, pr;
    if (rst) begin
      m_d0 = '0; m_d1 = '0; m_stable = '0; m_pulse = '0;
      for (int b = 0; b < 3; b++) m_win[b] = '0;
    end else begin
      seen = m_d1; m_d1 = m_d0; m_d0 = raw; pr = '0;
      for (int b = 0; b < 3; b++) begin
        m_win[b] = {m_win[b][DC-2:0], seen[b]};
        if (m_win[b] == {DC{~m_stable[b]}}) begin
          m_stable[b] = seen[b];
          pr[b]       = seen[b];
        end
      end
`ifdef BTN_ONEHOT_ARB_EN
      if (pr[1])      pr = 3'b010;
      else if (pr[2]) pr = 3'b100;
`endif
      m_pulse = pr;
    end
  endtask

  int edge_n;
  int cnt_l, cnt_c, cnt_r;
  int f_l, f_c, f_r;

  task automatic clr_stats();
    edge_n = 0; cnt_l = 0; cnt_c = 0; cnt_r = 0; f_l = -1; f_c = -1; f_r = -1;
  endtask

  task automatic step(input logic l, input logic c, input logic r, input logic rst);
    @(negedge CLK);
    BTNL_IN = l; BTNC_IN = c; BTNR_IN = r; RESET = rst;
    @(posedge CLK);
    #1;
    model_edge({l, c, r}, rst);
    chk("pulses", {29'd0, BTNL, BTNC, BTNR}, {29'd0, m_pulse});
    chk("level",  {29'd0, BTN_LEVEL},        {29'd0, m_stable});
    if (BTNL) begin cnt_l++; if (f_l < 0) f_l = edge_n; end
    if (BTNC) begin cnt_c++; if (f_c < 0) f_c = edge_n; end
    if (BTNR) begin cnt_r++; if (f_r < 0) f_r = edge_n; end
    edge_n++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_outs", {28'd0, BTNL, BTNC, BTNR, 1'b0}, 32'd0);
    chk("rst_level", {29'd0, BTN_LEVEL}, 32'd0);
    clr_stats();
  endtask

  initial begin
    logic [2:0] rb;
    logic       rr;

    // Clean centre press held 20 cycles
    do_reset(3);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("c_press_edge", f_c, 5);
    chk("c_press_cnt", cnt_c, 1);
    chk("c_press_lr", cnt_l + cnt_r, 0);
    chk("c_press_lvl", {29'd0, BTN_LEVEL}, 32'b010);

    // Short left glitches never qualify
    do_reset(3);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("glitch_cnt", cnt_l, 0);
    chk("glitch_lvl", {29'd0, BTN_LEVEL}, 32'd0);

    // Right press with bounce, then release
    do_reset(3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bounce_edge", f_r, 7);
    chk("bounce_cnt", cnt_r, 1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("release_cnt", cnt_r, 1);
    chk("release_lvl", {29'd0, BTN_LEVEL}, 32'd0);

    // Simultaneous left + centre
    do_reset(3);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("simul_c_edge", f_c, 5);
`ifdef BTN_ONEHOT_ARB_EN
    chk("simul_l_cnt", cnt_l, 0);
`else
    chk("simul_l_cnt", cnt_l, 1);
    chk("simul_l_edge", f_l, 5);
`endif
    chk("simul_lvl", {29'd0, BTN_LEVEL}, 32'b110);

    // Reset while centre held at cnt=2; post-reset edge 6 restarts at 0
    do_reset(3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("midrst_edge", f_c, 11);
    chk("midrst_cnt", cnt_c, 1);

    // Long hold
    do_reset(3);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("hold_cnt", cnt_r, 1);

    // Random bouncing with occasional reset
    do_reset(2);
    rb = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 5) == 0) rb[b] = ~rb[b];
      rr = ($urandom_range(0, 199) == 0);
      step(rb[2], rb[1], rb[0], rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
